// File: rtl/quad_mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the uFork quad-cell memory.
// Latency from the grant edge: write/refused ack in cycle 2, read ack in cycle 3.
// Backpressure: req/ack handshake; a requester holds req and operands until its ack.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_rom_wp                   ROM write-protect, sampled at grant
//   i_req*/i_wr*/i_addr*/      per-requester access (addr = {bank, quad addr})
//   i_field*/i_data*
//   o_ack*, o_err, o_rdata     registered completion pulse, refusal flag, read data
//   o_mem_*, o_cs_*            registered memory controls, live for the ISSUE cycle only
//   i_mem_data                 memory read data, valid one cycle after a read issue
module quad_mem_arbiter #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 12,
    parameter int BANK_SZ = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_rom_wp,
    input  logic                       i_req0,
    input  logic                       i_req1,
    input  logic                       i_wr0,
    input  logic                       i_wr1,
    input  logic [BANK_SZ+ADDR_SZ-1:0] i_addr0,
    input  logic [BANK_SZ+ADDR_SZ-1:0] i_addr1,
    input  logic [1:0]                 i_field0,
    input  logic [1:0]                 i_field1,
    input  logic [DATA_SZ-1:0]         i_data0,
    input  logic [DATA_SZ-1:0]         i_data1,
    output logic                       o_ack0,
    output logic                       o_ack1,
    output logic [DATA_SZ-1:0]         o_rdata,
    output logic                       o_err,
    output logic                       o_mem_wr,
    output logic [ADDR_SZ-1:0]         o_mem_addr,
    output logic [1:0]                 o_mem_field,
    output logic [DATA_SZ-1:0]         o_mem_data,
    output logic                       o_cs_ram,
    output logic                       o_cs_rom0,
    output logic                       o_cs_rom1,
    input  logic [DATA_SZ-1:0]         i_mem_data
);

    localparam int AW = BANK_SZ + ADDR_SZ;

    localparam logic [1:0] BANK_ROM0 = 2'b00;
    localparam logic [1:0] BANK_ROM1 = 2'b01;
    localparam logic [1:0] BANK_RAM  = 2'b10;
    localparam logic [1:0] BANK_BAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;        // last grantee; also the owner of the access in flight
    logic                 wr_q, wr_d;
    logic                 refused_q, refused_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 err_q, err_d;
    logic [DATA_SZ-1:0]   rdata_q, rdata_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_SZ-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]           mem_field_q, mem_field_d;
    logic [DATA_SZ-1:0]   mem_data_q, mem_data_d;
    logic                 cs_ram_q, cs_ram_d;
    logic                 cs_rom0_q, cs_rom0_d;
    logic                 cs_rom1_q, cs_rom1_d;

    // Candidate grant: on a tie the requester that did not win last time.
    logic                 gnt_sel;
    logic                 sel_wr;
    logic [AW-1:0]        sel_addr;
    logic [1:0]           sel_field;
    logic [DATA_SZ-1:0]   sel_data;
    logic [1:0]           sel_bank;
    logic                 sel_refuse;

    always_comb begin
        gnt_sel    = (i_req0 && i_req1) ? ~last_q : i_req1;
        sel_wr     = gnt_sel ? i_wr1    : i_wr0;
        sel_addr   = gnt_sel ? i_addr1  : i_addr0;
        sel_field  = gnt_sel ? i_field1 : i_field0;
        sel_data   = gnt_sel ? i_data1  : i_data0;
        sel_bank   = sel_addr[AW-1 -: 2];
        // Write-protect is judged here, at grant, and the verdict is latched.
        sel_refuse = (sel_bank == BANK_BAD) ||
                     (sel_wr && (sel_bank != BANK_RAM) && i_rom_wp);
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wr_d        = wr_q;
        refused_d   = refused_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_field_d = mem_field_q;
        mem_data_d  = mem_data_q;
        cs_ram_d    = 1'b0;
        cs_rom0_d   = 1'b0;
        cs_rom1_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    state_d     = S_ISSUE;
                    last_d      = gnt_sel;
                    wr_d        = sel_wr;
                    refused_d   = sel_refuse;
                    // Memory controls are loaded now so they are flop outputs
                    // for exactly the ISSUE cycle.
                    mem_addr_d  = sel_addr[ADDR_SZ-1:0];
                    mem_field_d = sel_field;
                    mem_data_d  = sel_data;
                    mem_wr_d    = sel_wr && !sel_refuse;
                    cs_ram_d    = !sel_refuse && (sel_bank == BANK_RAM);
                    cs_rom0_d   = !sel_refuse && (sel_bank == BANK_ROM0);
                    cs_rom1_d   = !sel_refuse && (sel_bank == BANK_ROM1);
                end
            end
            S_ISSUE: begin
                if (refused_q || wr_q) begin
                    state_d = S_ACK;
                    ack0_d  = !last_q;
                    ack1_d  = last_q;
                    err_d   = refused_q;
                    if (refused_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Memory output is registered: it is valid in this cycle.
                state_d = S_ACK;
                rdata_d = i_mem_data;
                ack0_d  = !last_q;
                ack1_d  = last_q;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            wr_q        <= 1'b0;
            refused_q   <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_field_q <= '0;
            mem_data_q  <= '0;
            cs_ram_q    <= 1'b0;
            cs_rom0_q   <= 1'b0;
            cs_rom1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            refused_q   <= refused_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_field_q <= mem_field_d;
            mem_data_q  <= mem_data_d;
            cs_ram_q    <= cs_ram_d;
            cs_rom0_q   <= cs_rom0_d;
            cs_rom1_q   <= cs_rom1_d;
        end
    end

    assign o_ack0      = ack0_q;
    assign o_ack1      = ack1_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign o_mem_wr    = mem_wr_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_field = mem_field_q;
    assign o_mem_data  = mem_data_q;
    assign o_cs_ram    = cs_ram_q;
    assign o_cs_rom0   = cs_rom0_q;
    assign o_cs_rom1   = cs_rom1_q;

endmodule

// File: tb/tb_quad_mem_arbiter.sv
// Testbench for quad_mem_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a transaction-level model.
module tb_quad_mem_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wp    = 1'b0;
    logic [1:0]  req   = 2'b00;
    logic [1:0]  wr    = 2'b00;
    logic [13:0] addr [2];
    logic [1:0]  fld  [2];
    logic [15:0] dat  [2];

    logic        ack0, ack1, err, mem_wr, cs_ram, cs_rom0, cs_rom1;
    logic [15:0] rdata, mem_data;
    logic [11:0] mem_addr;
    logic [1:0]  mem_field;
    logic [15:0] mem_q = 16'h0;

    int n_cmp = 0;
    int n_bad = 0;

    quad_mem_arbiter #(.DATA_SZ(16), .ADDR_SZ(12), .BANK_SZ(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rom_wp   (wp),
        .i_req0     (req[0]),
        .i_req1     (req[1]),
        .i_wr0      (wr[0]),
        .i_wr1      (wr[1]),
        .i_addr0    (addr[0]),
        .i_addr1    (addr[1]),
        .i_field0   (fld[0]),
        .i_field1   (fld[1]),
        .i_data0    (dat[0]),
        .i_data1    (dat[1]),
        .o_ack0     (ack0),
        .o_ack1     (ack1),
        .o_rdata    (rdata),
        .o_err      (err),
        .o_mem_wr   (mem_wr),
        .o_mem_addr (mem_addr),
        .o_mem_field(mem_field),
        .o_mem_data (mem_data),
        .o_cs_ram   (cs_ram),
        .o_cs_rom0  (cs_rom0),
        .o_cs_rom1  (cs_rom1),
        .i_mem_data (mem_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- external memory (what the arbiter drives) ----------------
    logic [15:0] mem_dut [65536];
    logic [15:0] mem_idx;
    assign mem_idx = {(cs_ram ? 2'd2 : (cs_rom1 ? 2'd1 : 2'd0)), mem_addr, mem_field};

    always @(posedge clk) begin
        if (cs_ram || cs_rom0 || cs_rom1) begin
            if (mem_wr) mem_dut[mem_idx] <= mem_data;
            else        mem_q <= mem_dut[mem_idx];
        end
    end

    // ---------------- reference model ----------------
    // One access = grant edge, then 'len' cycles (ack in the last), then one
    // idle cycle before the next grant can be taken.
    logic [15:0] ref_mem [65536];
    int          ph = 0;
    int          len = 0;
    logic        g = 1'b0, last = 1'b1;
    logic        m_wr = 1'b0, m_ref = 1'b0;
    logic [1:0]  m_bank = 2'd0, m_fld = 2'd0;
    logic [11:0] m_addr = 12'd0;
    logic [15:0] m_data = 16'd0, rd_val = 16'd0, hold = 16'd0;
    logic        iss, ackp;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph = 0; last = 1'b1; hold = 16'd0;
        end else if (ph == 0) begin
            if (req[0] || req[1]) begin
                g      = (req[0] && req[1]) ? !last : req[1];
                last   = g;
                m_wr   = wr[g];
                m_bank = addr[g][13:12];
                m_addr = addr[g][11:0];
                m_fld  = fld[g];
                m_data = dat[g];
                m_ref  = (m_bank == 2'd3) || (m_wr && m_bank != 2'd2 && wp);
                len    = (m_wr || m_ref) ? 2 : 3;
                ph     = 1;
            end
        end else if (ph == len) begin
            ph = 0;
        end else begin
            if (ph == 1 && !m_ref) begin
                if (m_wr) ref_mem[{m_bank, m_addr, m_fld}] = m_data;
                else      rd_val = ref_mem[{m_bank, m_addr, m_fld}];
            end
            ph++;
            if (ph == len) begin
                if (m_ref)      hold = 16'd0;
                else if (!m_wr) hold = rd_val;
            end
        end
        #1;
        iss  = (ph == 1) && !m_ref;
        ackp = (ph != 0) && (ph == len);
        chk("mon_cs_ram",  32'(cs_ram),  32'(iss && m_bank == 2'd2));
        chk("mon_cs_rom0", 32'(cs_rom0), 32'(iss && m_bank == 2'd0));
        chk("mon_cs_rom1", 32'(cs_rom1), 32'(iss && m_bank == 2'd1));
        chk("mon_mem_wr",  32'(mem_wr),  32'(iss && m_wr));
        if (ph == 1) begin
            chk("mon_mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mon_mem_field", 32'(mem_field), 32'(m_fld));
            chk("mon_mem_data",  32'(mem_data),  32'(m_data));
        end
        chk("mon_ack0",  32'(ack0),  32'(ackp && g == 1'b0));
        chk("mon_ack1",  32'(ack1),  32'(ackp && g == 1'b1));
        chk("mon_err",   32'(err),   32'(ackp && m_ref));
        chk("mon_rdata", 32'(rdata), 32'(hold));
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int          rid;
        logic        wp;
        logic        wr;
        logic [13:0] addr;
        logic [1:0]  fld;
        logic [15:0] dat;
        logic [2:0]  cs;     // {ram, rom1, rom0}
        logic        mwr;
        logic        err;
        int          lat;
        logic [15:0] rdat;
    } vec_t;

    vec_t vt [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat;
        req[v.rid]  = 1'b1;
        wr[v.rid]   = v.wr;
        addr[v.rid] = v.addr;
        fld[v.rid]  = v.fld;
        dat[v.rid]  = v.dat;
        wp          = v.wp;
        step();
        chk($sformatf("vec%0d_cs", i), 32'({cs_ram, cs_rom1, cs_rom0}), 32'(v.cs));
        chk($sformatf("vec%0d_mem_wr", i), 32'(mem_wr), 32'(v.mwr));
        chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(v.addr[11:0]));
        chk($sformatf("vec%0d_mem_field", i), 32'(mem_field), 32'(v.fld));
        if (v.mwr) chk($sformatf("vec%0d_mem_data", i), 32'(mem_data), 32'(v.dat));
        lat = 1;
        while (!(ack0 || ack1) && lat < 6) begin
            step();
            lat++;
        end
        chk($sformatf("vec%0d_latency", i), lat, v.lat);
        chk($sformatf("vec%0d_ack_id", i), 32'({ack1, ack0}), (v.rid == 0) ? 32'd1 : 32'd2);
        chk($sformatf("vec%0d_err", i), 32'(err), 32'(v.err));
        if (!v.wr || v.err) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(v.rdat));
        req[v.rid] = 1'b0;
        step();
        chk($sformatf("vec%0d_ack_pulse", i), 32'({ack1, ack0}), 32'd0);
    endtask

    task automatic new_op(input int r);
        wr[r]   = 1'($urandom_range(0, 1));
        addr[r] = {2'($urandom_range(0, 3)), 9'd0, 3'($urandom_range(0, 7))};
        fld[r]  = 2'($urandom_range(0, 3));
        dat[r]  = 16'($urandom);
    endtask

    initial begin
        int order[$];
        int lat;
        logic [1:0] prev;
        int n_ack [2];

        for (int i = 0; i < 65536; i++) begin
            mem_dut[i] <= 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        for (int r = 0; r < 2; r++) begin
            addr[r] = 14'd0; fld[r] = 2'd0; dat[r] = 16'd0; n_ack[r] = 0;
        end

        //            rid wp  wr  addr      fld  dat       cs      mwr err lat rdat
        vt[0]  = '{0, 1'b0, 1'b1, 14'h2005, 2'd2, 16'hBEEF, 3'b100, 1'b1, 1'b0, 2, 16'h0000};
        vt[1]  = '{1, 1'b0, 1'b0, 14'h2005, 2'd2, 16'h0000, 3'b100, 1'b0, 1'b0, 3, 16'hBEEF};
        vt[2]  = '{0, 1'b1, 1'b1, 14'h0010, 2'd0, 16'h1234, 3'b000, 1'b0, 1'b1, 2, 16'h0000};
        vt[3]  = '{0, 1'b0, 1'b1, 14'h0010, 2'd0, 16'h1234, 3'b001, 1'b1, 1'b0, 2, 16'h0000};
        vt[4]  = '{1, 1'b1, 1'b0, 14'h0010, 2'd0, 16'h0000, 3'b001, 1'b0, 1'b0, 3, 16'h1234};
        vt[5]  = '{1, 1'b0, 1'b0, 14'h3ABC, 2'd3, 16'h0000, 3'b000, 1'b0, 1'b1, 2, 16'h0000};
        vt[6]  = '{0, 1'b1, 1'b1, 14'h1020, 2'd1, 16'h7777, 3'b000, 1'b0, 1'b1, 2, 16'h0000};
        vt[7]  = '{0, 1'b0, 1'b0, 14'h1020, 2'd1, 16'h0000, 3'b010, 1'b0, 1'b0, 3, 16'h1ADB};
        vt[8]  = '{1, 1'b0, 1'b1, 14'h1FFF, 2'd3, 16'hA5A5, 3'b010, 1'b1, 1'b0, 2, 16'h0000};
        vt[9]  = '{0, 1'b1, 1'b0, 14'h1FFF, 2'd3, 16'h0000, 3'b010, 1'b0, 1'b0, 3, 16'hA5A5};
        vt[10] = '{1, 1'b0, 1'b1, 14'h3000, 2'd0, 16'h1111, 3'b000, 1'b0, 1'b1, 2, 16'h0000};
        vt[11] = '{1, 1'b1, 1'b1, 14'h2FFF, 2'd1, 16'h0F0F, 3'b100, 1'b1, 1'b0, 2, 16'h0000};
        vt[12] = '{0, 1'b1, 1'b0, 14'h2FFF, 2'd1, 16'h0000, 3'b100, 1'b0, 1'b0, 3, 16'h0F0F};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   32'({ack1, ack0}), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_cs",    32'({cs_ram, cs_rom1, cs_rom0}), 32'd0);
        chk("rst_mem",   32'({mem_wr, mem_addr, mem_field, mem_data}), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- directed table ----
        for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

        // ---- both requesters from reset: strict alternation ----
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wp = 1'b0;
        for (int r = 0; r < 2; r++) begin
            req[r] = 1'b1; wr[r] = 1'b1; addr[r] = 14'h2040 + 14'(r); fld[r] = 2'd0; dat[r] = 16'($urandom);
        end
        prev = 2'b00;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            step();
            if (prev != 2'b00) chk("fair_pulse_len", 32'({ack1, ack0}), 32'd0);
            prev = {ack1, ack0};
            if (ack0) begin order.push_back(0); dat[0] = 16'($urandom); end
            if (ack1) begin order.push_back(1); dat[1] = 16'($urandom); end
        end
        chk("fair_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk($sformatf("fair_order%0d", i), order[i], i % 2);
        req[1] = 1'b0;
        for (int c = 0; c < 8 && !ack0; c++) step();
        req[0] = 1'b0;
        repeat (2) step();

        // ---- reset during the ISSUE of a ram write ----
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 14'h2100; fld[0] = 2'd1; dat[0] = 16'hC0DE;
        step();
        chk("rstmid_cs_before", 32'({cs_ram, mem_wr}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_cs_ram", 32'(cs_ram), 32'd0);
        chk("rstmid_mem_wr", 32'(mem_wr), 32'd0);
        step();
        chk("rstmid_no_ack_a", 32'({ack1, ack0}), 32'd0);
        step();
        chk("rstmid_no_ack_b", 32'({ack1, ack0}), 32'd0);
        rst_n = 1'b1;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 14'h2005; fld[1] = 2'd2;
        lat = 0;
        while (!(ack0 || ack1) && lat < 6) begin step(); lat++; end
        chk("postrst_first_ack", 32'({ack1, ack0}), 32'd1);
        chk("postrst_first_lat", lat, 2);
        req[0] = 1'b0;
        lat = 0;
        while (!ack1 && lat < 8) begin step(); lat++; end
        chk("postrst_second_ack", 32'(ack1), 32'd1);
        chk("postrst_second_rdata", 32'(rdata), 32'hBEEF);
        req[1] = 1'b0;
        step();

        // ---- randomized traffic, checked by the model every cycle ----
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (req[r] && ((r == 0) ? ack0 : ack1)) begin
                    n_ack[r]++;
                    if ($urandom_range(0, 1) == 1) new_op(r);
                    else req[r] = 1'b0;
                end else if (!req[r] && $urandom_range(0, 2) == 0) begin
                    new_op(r);
                    req[r] = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0) wp = ~wp;
        end
        chk("rand_acks0_seen", 32'(n_ack[0] > 100), 32'd1);
        chk("rand_acks1_seen", 32'(n_ack[1] > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_mem_arbiter.md
Name: quad_mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the uFork quad-cell memory (RAM, ROM bank 0, ROM bank 1).
- Decodes a bank-tagged quad address into chip selects and drives registered memory control for exactly one cycle per access.
- Absorbs the memory's one-cycle registered read latency and returns a req/ack handshake to each requester.
- Requester 0 is the CPU; requester 1 is the loader/GC port.

Parameters:
- DATA_SZ, 16: bits per memory word.
- ADDR_SZ, 12: quad address bits presented to the memory.
- BANK_SZ, 2: bank tag bits, carried above the quad address on requester ports; fixed at 2.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rom_wp  in  1  ROM write-protect; 1 = writes to rom0/rom1 refused
- i_req0, i_req1  in  1  access request, requester 0/1
- i_wr0, i_wr1  in  1  {0:read, 1:write}
- i_addr0, i_addr1  in  BANK_SZ+ADDR_SZ  {bank[1:0], quad addr}; bank 00:rom0, 01:rom1, 10:ram, 11:invalid
- i_field0, i_field1  in  2  quad field {0:T, 1:X, 2:Y, 3:Z}
- i_data0, i_data1  in  DATA_SZ  write data
- o_ack0, o_ack1  out  1  one-cycle completion pulse
- o_rdata  out  DATA_SZ  read data, valid while either ack is high
- o_err  out  1  high with ack when the access was refused
- o_mem_wr  out  1  to memory i_wr
- o_mem_addr  out  ADDR_SZ  to memory i_addr
- o_mem_field  out  2  to memory i_field
- o_mem_data  out  DATA_SZ  to memory i_data
- o_cs_ram, o_cs_rom0, o_cs_rom1  out  1  to memory chip selects
- i_mem_data  in  DATA_SZ  from memory o_data, registered, valid 1 cycle after a read issue

Behaviour:
- Reset (i_rst_n=0, async): all outputs 0; state IDLE; last-grant pointer = 1, so requester 0 wins the first tie. A reset mid-access aborts it: chip selects drop immediately and no ack is issued.
- All outputs are registered. No combinational path from any requester input to any output.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant it.
- IDLE, both requests: grant the requester that is not the last-granted one.
- On grant: latch wr/addr/field/data, set the pointer to the grantee, go to ISSUE.
- ISSUE (exactly 1 cycle): drive o_mem_addr, o_mem_field, o_mem_data and o_mem_wr from the latch. Assert exactly one chip select per the bank tag. Next state: WAIT if read, ACK if write.
- Refused access (bank 11, or write to rom0/rom1 while i_rom_wp=1): no chip select and o_mem_wr=0 during ISSUE. Go straight to ACK with o_err=1 and o_rdata=0.
- WAIT: capture i_mem_data into o_rdata; go to ACK.
- ACK (1 cycle): pulse o_ackN for the grantee only; o_err valid. Go to IDLE.
- Outside ISSUE: o_cs_* = 0 and o_mem_wr = 0.
- o_rdata holds its last value outside ACK. On write acks it is unchanged (don't-care).
- Latency, counted from the edge at which IDLE samples req: write ack in the 2nd cycle, read ack in the 3rd cycle, refused access ack in the 2nd cycle.
- Throughput: 1 access per 3 cycles (write/refused) or 4 cycles (read).
- Requester rules: hold req and all operands stable until its ack; drop req in the cycle after ack. A req still high in the IDLE following its ack is a new request.
- Fairness: with both requesting continuously, grants strictly alternate. No requester waits more than one other access.
- i_rom_wp is sampled at grant, not during ISSUE.

Test Plan:
- Reset release, req0 write addr=0x2005 (ram, quad 0x005), field=2, data=0xBEEF -> ISSUE: o_cs_ram=1, o_mem_wr=1, o_mem_addr=0x005, o_mem_field=2, o_mem_data=0xBEEF; o_ack0 pulses 2 cycles after grant edge, o_err=0.
- req1 read of same addr/field with memory model -> o_ack1 on 3rd cycle, o_rdata=0xBEEF; o_ack0 stays 0.
- req0 and req1 asserted on the same edge after reset, both held 4 accesses -> grant order 0,1,0,1; each ack pulse is exactly 1 cycle.
- i_rom_wp=1, req0 write addr=0x0010 (rom0) data=0x1234 -> no chip select during ISSUE, o_ack0 with o_err=1. Repeat with i_rom_wp=0 -> o_cs_rom0=1, o_mem_wr=1, o_err=0.
- req1 read addr=0x3ABC (bank 11) -> no chip select, o_ack1 with o_err=1, o_rdata=0.
- Assert i_rst_n=0 during the ISSUE of a ram write -> o_cs_ram and o_mem_wr drop without waiting for a clock edge; no ack. After release, req0 is granted first.
